// File: rtl/bit_serializer_pkg.sv
// Shared types and default constants for the bit serializer.
// The optional parity bit is enabled by BIT_SERIALIZER_PARITY_EN.
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY
   } ser_state_t;

   localparam int   SER_WIDTH_DEF = 8;
   localparam logic SER_IDLE_BIT  = 1'b0;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding buffer that sits in front of the shifter so that
// back-to-back words can stream without gaps.
module ser_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one bit per clock out, MSB first.
// Defining BIT_SERIALIZER_PARITY_EN appends one even-parity bit per word.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH    = SER_WIDTH_DEF,
   parameter logic IDLE_BIT = SER_IDLE_BIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   ser_state_t       state, nxt_state;
   logic [CW-1:0]    bit_cnt, nxt_cnt;
   logic [WIDTH-1:0] shifter, nxt_shift, hold_q, aligned;
   logic             hold_full, hold_load, hold_take;
   logic             xfer, last, nxt_x, nxt_valid, nxt_done;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic             par, nxt_par;
`endif

   assign din_ready = !hold_full;
   assign xfer      = din_valid && din_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
   assign last = (state == ST_PARITY);
`else
   assign last = (state == ST_DATA) && (bit_cnt == LAST_CNT);
`endif

   ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk   (clk),
      .reset (reset),
      .load  (hold_load),
      .take  (hold_take),
      .d     (din),
      .q     (hold_q),
      .full  (hold_full)
   );

   always_comb begin
      nxt_state = state;
      nxt_cnt   = bit_cnt;
      nxt_shift = shifter;
      hold_load = 1'b0;
      hold_take = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      nxt_par   = par;
`endif

      case (state)
         ST_DATA: begin
            if (bit_cnt != LAST_CNT) begin
               nxt_cnt = bit_cnt + 1'b1;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
               nxt_state = ST_PARITY;
`else
               nxt_state = ST_IDLE;
               nxt_cnt   = '0;
`endif
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         ST_PARITY: begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
         end
`endif
         default: ;
      endcase

      // A held word always wins the free shifter; din_ready is low then,
      // so no transfer can collide with the handoff.
      if (last && hold_full) begin
         hold_take = 1'b1;
         nxt_state = ST_DATA;
         nxt_cnt   = '0;
         nxt_shift = hold_q;
`ifdef BIT_SERIALIZER_PARITY_EN
         nxt_par   = ^hold_q;
`endif
      end else if (xfer) begin
         if (state == ST_IDLE || last) begin
            nxt_state = ST_DATA;
            nxt_cnt   = '0;
            nxt_shift = din;
`ifdef BIT_SERIALIZER_PARITY_EN
            nxt_par   = ^din;
`endif
         end else begin
            hold_load = 1'b1;
         end
      end

      // Outputs are registered, so they are derived from the next state.
      aligned   = nxt_shift << nxt_cnt;
      nxt_x     = IDLE_BIT;
      nxt_valid = (nxt_state != ST_IDLE);
      nxt_done  = 1'b0;
      case (nxt_state)
         ST_DATA: begin
            nxt_x = aligned[WIDTH-1];
`ifndef BIT_SERIALIZER_PARITY_EN
            nxt_done = (nxt_cnt == LAST_CNT);
`endif
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         ST_PARITY: begin
            nxt_x    = nxt_par;
            nxt_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shifter   <= '0;
         x         <= IDLE_BIT;
         x_valid   <= 1'b0;
         word_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state     <= nxt_state;
         bit_cnt   <= nxt_cnt;
         shifter   <= nxt_shift;
         x         <= nxt_x;
         x_valid   <= nxt_valid;
         word_done <= nxt_done;
`ifdef BIT_SERIALIZER_PARITY_EN
         par       <= nxt_par;
`endif
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed and random words against a bit-queue model
// of the expected serial stream, checked every cycle.
module tb_bit_serializer;

   localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic         clk = 1'b1;
   logic         reset = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready, x, x_valid, word_done;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .x         (x),
      .x_valid   (x_valid),
      .word_done (word_done)
   );

   // Expected stream: front entry is the bit on x in the current cycle.
   typedef struct packed {logic b; logic last;} ebit_t;
   ebit_t        expq[$];
   logic [W-1:0] src[$];
   int           ncmp = 0;
   int           nerr = 0;

   // A word occupies the block until its final bit has been shown; a second
   // such word means the hold register is full.
   function automatic int words_in_flight();
      int n = 0;
      foreach (expq[i]) if (expq[i].last) n++;
      return n;
   endfunction

   function automatic logic exp_ready();
      return words_in_flight() < 2;
   endfunction

   task automatic check(input string tag, input logic got, input logic exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic v;
      v = (expq.size() != 0);
      check("x_valid", x_valid, v);
      check("x", x, v ? expq[0].b : 1'b0);
      check("word_done", word_done, v ? expq[0].last : 1'b0);
      check("din_ready", din_ready, exp_ready());
   endtask

   task automatic push_word(input logic [W-1:0] w);
      ebit_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.b    = w[i];
         e.last = (i == 0) && !PAR;
         expq.push_back(e);
      end
      if (PAR) begin
         e.b    = ^w;
         e.last = 1'b1;
         expq.push_back(e);
      end
   endtask

   task automatic cyc(input logic v, input logic [W-1:0] d, output logic acc);
      ebit_t drop;
      din_valid = v;
      din       = d;
      acc       = v && exp_ready();
      @(posedge clk);
      #1;
      if (expq.size() != 0) drop = expq.pop_front();
      if (acc) push_word(d);
      check_outputs();
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cyc(1'b0, '0, acc);
   endtask

   // Presents src words in order with din_valid held until each is taken.
   task automatic stream();
      logic acc;
      for (int c = 0; c < 400 && src.size() != 0; c++) begin
         cyc(1'b1, src[0], acc);
         if (acc) src.delete(0);
      end
      check("stream_timeout", src.size() == 0, 1'b1);
      din_valid = 1'b0;
   endtask

   initial begin
      logic acc;

      // Reset held for 15 ns with no input.
      #2  check_outputs();
      #10 check_outputs();
      #3  reset = 1'b0;
      idle(3);

      // Single word.
      cyc(1'b1, 8'hA5, acc);
      idle(12);

      // Back-to-back pair, then three words presented continuously.
      src = '{8'hA5, 8'h5A};
      stream();
      idle(20);
      src = '{8'hC3, 8'h96, 8'h3C};
      stream();
      idle(30);

      // Reset during bit 3 of 8'hFF while 8'h33 sits in the hold register.
      cyc(1'b1, 8'hFF, acc);
      cyc(1'b1, 8'h33, acc);
      cyc(1'b0, '0, acc);
      cyc(1'b0, '0, acc);
      check("hold_before_reset", din_ready, 1'b0);
      #2 reset = 1'b1;
      expq.delete();
      #1 check_outputs();
      @(posedge clk);
      #1 check_outputs();
      #3 reset = 1'b0;
      idle(20);

      // Parity-sensitive words (odd and even number of ones).
      cyc(1'b1, 8'h07, acc);
      idle(12);
      cyc(1'b1, 8'h03, acc);
      idle(12);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, W'($urandom), acc);
      end
      din_valid = 1'b0;
      idle(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
